// File: rtl/stream_arb_2to1_pkg.sv
// Shared definitions for the two-input round-robin stream arbiter.
//   SRC_IN0 / SRC_IN1 : source index encodings carried on out_src and last_src
//   DEFAULT_WIDTH     : default payload width of every stream
//   state_t           : output-register occupancy (EMPTY / FULL)
package stream_arb_2to1_pkg;

    localparam logic SRC_IN0 = 1'b0;
    localparam logic SRC_IN1 = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage : stream_arb_2to1_pkg

// File: rtl/stream_arb_2to1_if.sv
// Bundle of all stream signals around the arbiter.
//   in0_* / in1_* : producer-side valid/ready/data streams
//   out_*         : consumer-side valid/ready/data stream plus out_src tag
// Modports:
//   slave  : the arbiter (consumes in0/in1, produces out)
//   master : the environment (drives producers and the consumer's ready)
interface stream_arb_2to1_if #(
    parameter int WIDTH = stream_arb_2to1_pkg::DEFAULT_WIDTH
);
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_src;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );
endinterface : stream_arb_2to1_if

// File: rtl/stream_arb_2to1_mux.sv
// Single-bit 2:1 multiplexer used as the arbiter's data-select slice.
//   sel : 0 selects in0, 1 selects in1
//   in0 : input for sel=0
//   in1 : input for sel=1
//   y   : selected output
module mux_2to1 (
    input  logic sel,
    input  logic in0,
    input  logic in1,
    output logic y
);
    assign y = sel ? in1 : in0;
endmodule : mux_2to1

// File: rtl/stream_arb_2to1.sv
// Two-input round-robin stream arbiter with one registered output stage.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : stream bundle (slave side) - in0/in1 producers, out consumer,
//         out_src tags which source the held word came from.
// The output register is refilled whenever it is empty or being drained
// (load_en), so a continuously ready consumer sees one word per cycle.
module stream_arb_2to1
    import stream_arb_2to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    stream_arb_2to1_if.slave       bus
);

    state_t           state_q, state_d;
    logic             last_src_q, last_src_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;

    logic             load_en;
    logic             grant_valid;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    // ---------------- arbitration ----------------
    always_comb begin
        load_en     = (state_q == ST_EMPTY) || bus.out_ready;
        grant_valid = bus.in0_valid || bus.in1_valid;
        // On a tie the source that did not win last time gets the slot;
        // otherwise whichever single source is valid wins.
        if (bus.in0_valid && bus.in1_valid) begin
            grant = ~last_src_q;
        end else begin
            grant = bus.in1_valid ? SRC_IN1 : SRC_IN0;
        end
    end

    // Readies are forced low during reset so nothing is consumed in that cycle.
    assign bus.in0_ready = !rst && load_en && grant_valid && (grant == SRC_IN0);
    assign bus.in1_ready = !rst && load_en && grant_valid && (grant == SRC_IN1);

    assign accept = (bus.in0_valid && bus.in0_ready) ||
                    (bus.in1_valid && bus.in1_ready);

    // ---------------- data select ----------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
            mux_2to1 u_mux (
                .sel (grant),
                .in0 (bus.in0_data[gi]),
                .in1 (bus.in1_data[gi]),
                .y   (mux_data[gi])
            );
        end
    endgenerate

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            last_src_q <= SRC_IN1;   // in0 wins the first tie after reset
            out_data_q <= '0;
            out_src_q  <= SRC_IN0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        last_src_d = last_src_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        if (accept) begin
            // Covers both filling from EMPTY and drain-and-refill in FULL.
            state_d    = ST_FULL;
            last_src_d = grant;
            out_data_d = mux_data;
            out_src_d  = grant;
        end else if ((state_q == ST_FULL) && bus.out_ready) begin
            // Drained with nothing new: payload and tag are left as they were.
            state_d = ST_EMPTY;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.out_valid = (state_q == ST_FULL);
        bus.out_data  = out_data_q;
        bus.out_src   = out_src_q;
    end

endmodule : stream_arb_2to1
